// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit-side stream arbiter.
// The priority encoder and the top level both import this package.
package uart_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Ceiling log2 with a floor of 1, so that every counter keeps at least one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      while (r < 32 && (64'd1 << r) < 64'(n)) r++;
      return r;
   endfunction

   // Reset value of the round-robin pointer.
   // Setting it to the last port makes port 0 the first one searched.
   function automatic int unsigned ptr_reset(input int unsigned num_ports);
      return num_ports - 1;
   endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder.
// Returns the first requesting index, searching upward from ptr+1 and wrapping.
module rr_priority_encoder
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned ID_WIDTH  = 2
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [ID_WIDTH-1:0]  ptr,
   output logic [ID_WIDTH-1:0]  idx,
   output logic                 any_req
);

   logic [NUM_PORTS-1:0] rot;
   int unsigned          off;

   // Rotate the request vector so that bit 0 is port ptr+1.
   // The lowest set bit is then the winner.
   always_comb begin
      rot = NUM_PORTS'({req, req} >> (32'(ptr) + 32'd1));
      off = 0;
      for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
         if (rot[i]) off = 32'(i);
      end
      idx     = ID_WIDTH'((32'(ptr) + 32'd1 + off) % NUM_PORTS);
      any_req = |req;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that feeds one UART transmit stream.
// A grant is released on tlast, on the burst limit, or on a stall timeout.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned NUM_PORTS     = 4,
   parameter int unsigned ID_WIDTH      = 2,
   parameter int unsigned MAX_BURST     = 16,
   parameter int unsigned STALL_TIMEOUT = 1024
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]            s_axis_tlast,
   output logic [NUM_PORTS-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [ID_WIDTH-1:0]             m_axis_tid,
   output logic                            grant_active,
   output logic                            stall_timeout
);

   localparam int unsigned BEAT_W  = clog2(MAX_BURST + 1);
   localparam int unsigned STALL_W = clog2(STALL_TIMEOUT + 1);
   localparam logic [ID_WIDTH-1:0] PTR_INIT = ID_WIDTH'(ptr_reset(NUM_PORTS));

   state_t               state;
   logic [ID_WIDTH-1:0]  grant_id;
   logic [ID_WIDTH-1:0]  ptr;
   logic [ID_WIDTH-1:0]  arb_idx;
   logic                 arb_any;
   logic [BEAT_W-1:0]    beat_cnt;
   logic [STALL_W-1:0]   stall_cnt;
   logic                 tvalid_g;
   logic                 tlast_g;
   logic                 beat;
   logic                 burst_hit;
   logic                 release_beat;
   logic                 stall_hit;

   rr_priority_encoder #(
      .NUM_PORTS (NUM_PORTS),
      .ID_WIDTH  (ID_WIDTH)
   ) u_rr (
      .req     (s_axis_tvalid),
      .ptr     (ptr),
      .idx     (arb_idx),
      .any_req (arb_any)
   );

   // Zero-latency mux from the granted port.
   // Because state is reset asynchronously, a reset drops the data path at once.
   always_comb begin
      m_axis_tdata  = '0;
      tvalid_g      = 1'b0;
      tlast_g       = 1'b0;
      s_axis_tready = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         if (state == GRANT && grant_id == ID_WIDTH'(i)) begin
            m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            tvalid_g         = s_axis_tvalid[i];
            tlast_g          = s_axis_tlast[i];
            s_axis_tready[i] = m_axis_tready;
         end
      end
   end

   assign m_axis_tvalid = tvalid_g;
   assign grant_active  = (state == GRANT);
   assign m_axis_tid    = grant_active ? grant_id : '0;
   assign beat          = tvalid_g & m_axis_tready;
   assign burst_hit     = (MAX_BURST != 0) && (32'(beat_cnt) == MAX_BURST - 1);
   assign release_beat  = beat & (tlast_g | burst_hit);
   // Only cycles with the source idle count toward the stall; UART backpressure does not.
   assign stall_hit     = (STALL_TIMEOUT != 0) && (state == GRANT) && !tvalid_g &&
                          (32'(stall_cnt) == STALL_TIMEOUT - 1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         grant_id      <= '0;
         ptr           <= PTR_INIT;
         beat_cnt      <= '0;
         stall_cnt     <= '0;
         stall_timeout <= 1'b0;
      end else begin
         stall_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_any) begin
                  state     <= GRANT;
                  grant_id  <= arb_idx;
                  beat_cnt  <= '0;
                  stall_cnt <= '0;
               end
            end
            GRANT: begin
               if (release_beat || stall_hit) begin
                  state         <= IDLE;
                  ptr           <= grant_id;
                  beat_cnt      <= '0;
                  stall_cnt     <= '0;
                  stall_timeout <= stall_hit;
               end else if (beat) begin
                  beat_cnt  <= beat_cnt + BEAT_W'(1);
                  stall_cnt <= '0;
               end else if (!tvalid_g) begin
                  stall_cnt <= stall_cnt + STALL_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based requester models and a beat scoreboard.
// Expected {tid, data} words are queued as stimulus is planned and checked on every UART beat.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int unsigned NP = 4;
   localparam int unsigned DW = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [NP*DW-1:0] s_axis_tdata;
   logic [NP-1:0]   s_axis_tvalid;
   logic [NP-1:0]   s_axis_tlast;
   logic [NP-1:0]   s_axis_tready;
   logic [DW-1:0]   m_axis_tdata;
   logic            m_axis_tvalid;
   logic            m_axis_tready;
   logic [1:0]      m_axis_tid;
   logic            grant_active;
   logic            stall_timeout;

   int              pass_cnt = 0;
   int              total = 0;
   logic [8:0]      src_q [NP][$];
   logic [9:0]      exp_q [$];
   logic [NP-1:0]   en;
   logic [NP-1:0]   fire;
   logic            rdy_next;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .DATA_WIDTH    (8),
      .NUM_PORTS     (4),
      .ID_WIDTH      (2),
      .MAX_BURST     (16),
      .STALL_TIMEOUT (1024)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tid    (m_axis_tid),
      .grant_active  (grant_active),
      .stall_timeout (stall_timeout)
   );

   // Present each source queue head; ports that are idle carry random tdata/tlast.
   task automatic drive();
      for (int i = 0; i < int'(NP); i++) begin
         if (en[i] && src_q[i].size() != 0) begin
            s_axis_tvalid[i]         = 1'b1;
            s_axis_tlast[i]          = src_q[i][0][8];
            s_axis_tdata[i*DW +: DW] = src_q[i][0][7:0];
         end else begin
            s_axis_tvalid[i]         = 1'b0;
            s_axis_tlast[i]          = 1'($urandom);
            s_axis_tdata[i*DW +: DW] = 8'($urandom);
         end
      end
      m_axis_tready = rdy_next;
   endtask

   task automatic tick_drive();
      @(posedge clk);
      #1;
      for (int i = 0; i < int'(NP); i++) begin
         if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      end
      drive();
   endtask

   task automatic tick_sample();
      logic [9:0] e;
      @(negedge clk);
      fire = s_axis_tvalid & s_axis_tready;
      if (reset && m_axis_tvalid && m_axis_tready) begin
         total++;
         if (exp_q.size() == 0) begin
            $display("FAIL beat_unexpected: got tid=%0d data=%h, expected no beat", m_axis_tid, m_axis_tdata);
         end else begin
            e = exp_q.pop_front();
            if ({m_axis_tid, m_axis_tdata} !== e)
               $display("FAIL beat_order: got tid=%0d data=%h, expected tid=%0d data=%h",
                        m_axis_tid, m_axis_tdata, e[9:8], e[7:0]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic tick();
      tick_drive();
      tick_sample();
   endtask

   task automatic run_until_empty(input int budget, output bit ok);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      ok = (exp_q.size() == 0);
      tick();
      tick();
   endtask

   task automatic reset_dut();
      reset = 1'b0;
      for (int i = 0; i < int'(NP); i++) src_q[i].delete();
      exp_q.delete();
      en       = '1;
      rdy_next = 1'b1;
      fire     = '0;
      drive();
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      total++; if (s_axis_tready !== 4'b0) $display("FAIL reset_tready: got %b, expected 0000", s_axis_tready); else pass_cnt++;
      total++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b, expected 0", m_axis_tvalid); else pass_cnt++;
      total++; if (grant_active !== 1'b0) $display("FAIL reset_grant: got %b, expected 0", grant_active); else pass_cnt++;
      total++; if (stall_timeout !== 1'b0) $display("FAIL reset_stall: got %b, expected 0", stall_timeout); else pass_cnt++;
      total++; if (m_axis_tid !== 2'd0) $display("FAIL reset_tid: got %0d, expected 0", m_axis_tid); else pass_cnt++;
      total++; if (m_axis_tdata !== 8'h00) $display("FAIL reset_tdata: got %h, expected 00", m_axis_tdata); else pass_cnt++;
   endtask

   task automatic test_single_packet();
      src_q[0].push_back(9'h041);
      src_q[0].push_back(9'h042);
      src_q[0].push_back(9'h143);
      exp_q.push_back({2'd0, 8'h41});
      exp_q.push_back({2'd0, 8'h42});
      exp_q.push_back({2'd0, 8'h43});
      tick();
      total++;
      if (grant_active !== 1'b0 || m_axis_tvalid !== 1'b0)
         $display("FAIL single_bubble: got grant=%b tvalid=%b, expected 0 0", grant_active, m_axis_tvalid);
      else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if ({grant_active, m_axis_tid, s_axis_tready, m_axis_tvalid & m_axis_tready} !== {1'b1, 2'd0, 4'b0001, 1'b1})
            $display("FAIL single_beat%0d: got grant=%b tid=%0d tready=%b beat=%b, expected 1 0 0001 1",
                     k, grant_active, m_axis_tid, s_axis_tready, m_axis_tvalid & m_axis_tready);
         else pass_cnt++;
      end
      tick();
      total++; if (grant_active !== 1'b0) $display("FAIL single_release: got grant=%b, expected 0", grant_active); else pass_cnt++;
      total++; if (exp_q.size() != 0) $display("FAIL single_pending: got %0d beats left, expected 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      int cnt [NP];
      reset_dut();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < int'(NP); i++) begin
            src_q[i].push_back({1'b1, 8'(16 * i + 8 * r)});
            exp_q.push_back({2'(i), 8'(16 * i + 8 * r)});
         end
      end
      for (int i = 0; i < int'(NP); i++) cnt[i] = 0;
      for (int k = 0; k < 24; k++) begin
         tick();
         for (int i = 0; i < int'(NP); i++) cnt[i] += int'(s_axis_tready[i]);
      end
      for (int i = 0; i < int'(NP); i++) begin
         total++;
         if (cnt[i] != 2) $display("FAIL rr_tready_port%0d: got %0d ready cycles, expected 2", i, cnt[i]);
         else pass_cnt++;
      end
      total++; if (exp_q.size() != 0) $display("FAIL rr_pending: got %0d beats left, expected 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_burst_limit();
      bit ok;
      reset_dut();
      for (int k = 0; k < 20; k++) src_q[2].push_back({(k == 19), 8'(8'h20 + k)});
      src_q[3].push_back(9'h13F);
      for (int k = 0; k < 16; k++) exp_q.push_back({2'd2, 8'(8'h20 + k)});
      exp_q.push_back({2'd3, 8'h3F});
      for (int k = 16; k < 20; k++) exp_q.push_back({2'd2, 8'(8'h20 + k)});
      run_until_empty(80, ok);
      total++; if (!ok) $display("FAIL burst_timeout: got %0d beats left, expected 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      bit ok;
      int bad;
      reset_dut();
      src_q[1].push_back(9'h051);
      src_q[1].push_back(9'h052);
      src_q[1].push_back(9'h153);
      exp_q.push_back({2'd1, 8'h51});
      exp_q.push_back({2'd1, 8'h52});
      exp_q.push_back({2'd1, 8'h53});
      tick();
      tick();
      rdy_next = 1'b0;
      bad = 0;
      for (int k = 0; k < 5000; k++) begin
         tick();
         if (stall_timeout || !grant_active || !m_axis_tvalid || m_axis_tid != 2'd1) bad++;
      end
      total++; if (bad != 0) $display("FAIL bp_hold: got %0d bad cycles, expected 0", bad); else pass_cnt++;
      rdy_next = 1'b1;
      run_until_empty(20, ok);
      total++; if (!ok) $display("FAIL bp_drain: got %0d beats left, expected 0", exp_q.size()); else pass_cnt++;
      total++; if (grant_active !== 1'b0) $display("FAIL bp_release: got grant=%b, expected 0", grant_active); else pass_cnt++;
   endtask

   task automatic test_stall_timeout();
      bit ok;
      int pulses;
      int pulse_k;
      bit next_ok;
      reset_dut();
      src_q[0].push_back(9'h0A0);
      src_q[0].push_back(9'h1B0);
      src_q[1].push_back(9'h1C1);
      exp_q.push_back({2'd0, 8'hA0});
      exp_q.push_back({2'd1, 8'hC1});
      exp_q.push_back({2'd0, 8'hB0});
      tick();
      tick();
      en[0]   = 1'b0;
      pulses  = 0;
      pulse_k = -10;
      next_ok = 1'b0;
      for (int k = 1; k <= 1030; k++) begin
         tick();
         if (k == pulse_k + 1) next_ok = grant_active && (m_axis_tid == 2'd1);
         if (stall_timeout) begin
            pulses++;
            pulse_k = k;
         end
      end
      total++; if (pulses != 1) $display("FAIL stall_pulses: got %0d, expected 1", pulses); else pass_cnt++;
      total++; if (pulse_k != 1025) $display("FAIL stall_cycle: got %0d, expected 1025", pulse_k); else pass_cnt++;
      total++; if (!next_ok) $display("FAIL stall_next_grant: got %b, expected 1", next_ok); else pass_cnt++;
      en[0] = 1'b1;
      run_until_empty(20, ok);
      total++; if (!ok) $display("FAIL stall_drain: got %0d beats left, expected 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_async_reset();
      bit ok;
      src_q[2].push_back(9'h0D1);
      src_q[2].push_back(9'h0D2);
      src_q[2].push_back(9'h1D3);
      exp_q.push_back({2'd2, 8'hD1});
      tick();
      tick();
      tick_drive();
      #2 reset = 1'b0;
      #1;
      total++; if (m_axis_tvalid !== 1'b0) $display("FAIL ar_tvalid: got %b, expected 0", m_axis_tvalid); else pass_cnt++;
      total++; if (s_axis_tready !== 4'b0) $display("FAIL ar_tready: got %b, expected 0000", s_axis_tready); else pass_cnt++;
      total++; if (grant_active !== 1'b0) $display("FAIL ar_grant: got %b, expected 0", grant_active); else pass_cnt++;
      total++; if (m_axis_tid !== 2'd0) $display("FAIL ar_tid: got %0d, expected 0", m_axis_tid); else pass_cnt++;
      total++; if (m_axis_tdata !== 8'h00) $display("FAIL ar_tdata: got %h, expected 00", m_axis_tdata); else pass_cnt++;
      total++; if (exp_q.size() != 0) $display("FAIL ar_first_beat: got %0d beats left, expected 0", exp_q.size()); else pass_cnt++;
      for (int i = 0; i < int'(NP); i++) src_q[i].delete();
      fire = '0;
      drive();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      src_q[3].push_back(9'h1E3);
      src_q[0].push_back(9'h1E0);
      exp_q.push_back({2'd0, 8'hE0});
      exp_q.push_back({2'd3, 8'hE3});
      tick();
      tick();
      total++; if (m_axis_tid !== 2'd0) $display("FAIL ar_priority: got tid=%0d, expected 0", m_axis_tid); else pass_cnt++;
      run_until_empty(20, ok);
      total++; if (!ok) $display("FAIL ar_drain: got %0d beats left, expected 0", exp_q.size()); else pass_cnt++;
   endtask

   initial begin
      s_axis_tvalid = '0;
      s_axis_tlast  = '0;
      s_axis_tdata  = '0;
      m_axis_tready = 1'b1;
      reset_dut();
      test_reset();
      test_single_packet();
      test_round_robin();
      test_burst_limit();
      test_backpressure();
      test_stall_timeout();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter AXI-stream input among NUM_PORTS requesters (e.g. console, debug, telemetry sources).
- Uses round-robin arbitration with packet locking: a grant is held until the requester's tlast beat, a burst limit, or a stall timeout.
- Sits between the requester streams and the s_axis_* input of the UART top level.
- m_axis_tid exports the granted source index for tagging and debug.

Parameters:
- DATA_WIDTH, 8, width of each data beat; matches the UART DATA_WIDTH.
- NUM_PORTS, 4, number of requesters; legal range 2..16.
- ID_WIDTH, 2, width of the port index; must equal ceil(log2(NUM_PORTS)).
- MAX_BURST, 16, maximum beats per grant; 0 means unlimited (release only on tlast or timeout).
- STALL_TIMEOUT, 1024, consecutive idle cycles mid-grant before forced release; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous active-low reset (asserted when 0); deassertion is synchronous to clk.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  requester data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  NUM_PORTS  per-requester valid.
- s_axis_tlast  in  NUM_PORTS  per-requester end-of-packet.
- s_axis_tready  out  NUM_PORTS  per-requester ready.
- m_axis_tdata  out  DATA_WIDTH  to the UART s_axis_tdata.
- m_axis_tvalid  out  1  to the UART s_axis_tvalid.
- m_axis_tready  in  1  from the UART s_axis_tready.
- m_axis_tid  out  ID_WIDTH  index of the granted port.
- grant_active  out  1  high while a grant is held.
- stall_timeout  out  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset values: state IDLE; s_axis_tready, m_axis_tvalid, grant_active, stall_timeout all 0; m_axis_tid 0; m_axis_tdata 0 (mux output with no grant); rr pointer = NUM_PORTS-1, so port 0 has first priority.
- State machine, states IDLE and GRANT.
  - IDLE: if any s_axis_tvalid bit is set, choose the first set bit searching upward from (ptr+1) mod NUM_PORTS. Register grant_id and enter GRANT next cycle. No data moves in IDLE, so there is a 1-cycle arbitration bubble.
  - GRANT (g = grant_id):
    - Combinational data path: m_axis_tdata/tvalid come from port g; s_axis_tready[g] = m_axis_tready; all other tready bits are 0.
    - No registers in the data path, so data latency is 0 cycles.
    - grant_active = 1; m_axis_tid = g.
  - Release conditions, evaluated on a beat (m_axis_tvalid && m_axis_tready):
    - tlast[g] = 1; or
    - beat_cnt+1 == MAX_BURST (when MAX_BURST != 0).
  - On release: ptr <= g, return to IDLE, beat_cnt <= 0.
  - beat_cnt increments on each beat; its width is ceil(log2(MAX_BURST+1)).
- Stall handling:
  - Stall counter resets on every beat and on entering GRANT.
  - It increments each GRANT cycle in which s_axis_tvalid[g] = 0. Cycles where tvalid=1 and tready=0 are UART backpressure and do not count.
  - When it reaches STALL_TIMEOUT: release as above, pulse stall_timeout for one cycle, return to IDLE.
- Handshake rules:
  - m_axis_tvalid never depends on m_axis_tready.
  - A beat accepted in the release cycle is the last beat of the grant.
  - tdata/tlast of a non-granted port are ignored.
- Boundary conditions:
  - Simultaneous requests: strict round-robin; a port cannot be granted twice in a row while another port is requesting.
  - Single requester: it is re-granted after the 1-cycle bubble.
  - tlast and the burst limit on the same beat: a single release.
  - A requester dropping tvalid mid-packet is legal; the grant is held until timeout.
  - Reset asserted mid-grant: all outputs go to their reset values immediately (asynchronously); an in-flight beat is dropped and the UART sees tvalid fall.

Decomposition:
- Package uart_arb_pkg:
  - state enum {IDLE, GRANT};
  - function clog2;
  - constant for the ptr reset value.
- Sub-module rr_priority_encoder (NUM_PORTS req vector + ptr -> grant index + any_req), purely combinational. It is instantiated once and can be reused by a future RX distributor.

Test Plan:
- Port 0 only, 3-beat packet 0x41,0x42,0x43 (tlast on 0x43), UART tready=1 -> tid=0; beats pass in 3 consecutive cycles after a 1-cycle bubble; grant_active falls the cycle after 0x43.
- All 4 ports valid with 1-beat packets -> grant order 0,1,2,3,0; each port's tready is high exactly once per round.
- MAX_BURST=16, port 2 sends a 20-beat packet -> release after beat 16; port 3 (waiting) is granted next; port 2's remaining 4 beats follow in the later grant.
- UART holds tready=0 for 5000 cycles mid-packet with tvalid=1 -> no stall_timeout; the grant is held.
- Granted port drops tvalid for 1024 cycles (STALL_TIMEOUT=1024) -> stall_timeout pulses once; the next requester is granted 1 cycle later.
- reset driven low during beat 2 of a grant -> all outputs 0 asynchronously; after deassertion, port 0 has first priority.
